// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: gathers four little-endian bytes per instruction over the
// shared byte-wide RAM port and presents pc/instruction to decode through a one-word skid buffer.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        jump_in,
    input  logic [31:0] jump_addr_in,
    input  logic        mem_grant_in,
    input  logic [7:0]  mem_din_in,
    output logic [31:0] mem_a_out,
    output logic        mem_rd_en_out,
    output logic        inst_valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out
);

    typedef enum logic {
        S_FETCH,
        S_WAIT
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [2:0]  ic;
    logic [2:0]  rc;
    logic        pend;
    logic [23:0] byte_buf;
    logic [7:0]  last_byte;
    logic        live;
    logic        out_free;
    logic        issue;

    // live keeps the RAM port quiet (and at address 0) for the cycle following a reset edge
    always_comb begin
        mem_rd_en_out = live && (state == S_FETCH) && !ic[2];
        mem_a_out     = live ? fetch_pc + {29'b0, ic} : '0;
        out_free      = !inst_valid_out || !stall_in;
        issue         = mem_rd_en_out && mem_grant_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_FETCH;
            fetch_pc       <= RESET_PC;
            ic             <= '0;
            rc             <= '0;
            pend           <= 1'b0;
            byte_buf       <= '0;
            last_byte      <= '0;
            live           <= 1'b0;
            inst_valid_out <= 1'b0;
            pc_out         <= '0;
            inst_out       <= '0;
        end else begin
            live <= 1'b1;
            if (jump_in) begin
                // in-flight byte is dropped by clearing pend; pc_out/inst_out stay stale
                fetch_pc       <= jump_addr_in;
                ic             <= '0;
                rc             <= '0;
                pend           <= 1'b0;
                state          <= S_FETCH;
                inst_valid_out <= 1'b0;
            end else begin
                pend <= issue;
                if (issue)
                    ic <= ic + 3'd1;
                if (!stall_in)
                    inst_valid_out <= 1'b0;
                if (pend) begin
                    case (rc)
                        3'd0: begin byte_buf[7:0]   <= mem_din_in; rc <= 3'd1; end
                        3'd1: begin byte_buf[15:8]  <= mem_din_in; rc <= 3'd2; end
                        3'd2: begin byte_buf[23:16] <= mem_din_in; rc <= 3'd3; end
                        3'd3: begin
                            if (out_free) begin
                                inst_valid_out <= 1'b1;
                                pc_out         <= fetch_pc;
                                inst_out       <= {mem_din_in, byte_buf};
                                fetch_pc       <= fetch_pc + 32'd4;
                                ic             <= '0;
                                rc             <= '0;
                            end else begin
                                last_byte <= mem_din_in;
                                rc        <= 3'd4;
                                state     <= S_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
                if (state == S_WAIT && out_free) begin
                    inst_valid_out <= 1'b1;
                    pc_out         <= fetch_pc;
                    inst_out       <= {last_byte, byte_buf};
                    fetch_pc       <= fetch_pc + 32'd4;
                    ic             <= '0;
                    rc             <= '0;
                    state          <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed timing scenarios, then randomized stall/grant/jump/reset
// traffic checked against a program-order PC model and a byte-addressed RAM image.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall_in, jump_in, mem_grant_in;
    logic [31:0] jump_addr_in;
    logic [7:0]  mem_din_in;
    logic [31:0] mem_a_out, pc_out, inst_out;
    logic        mem_rd_en_out, inst_valid_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    int          low_run;
    logic        p_rst, p_jump, p_stall, p_valid;
    logic [31:0] p_addr;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .jump_in        (jump_in),
        .jump_addr_in   (jump_addr_in),
        .mem_grant_in   (mem_grant_in),
        .mem_din_in     (mem_din_in),
        .mem_a_out      (mem_a_out),
        .mem_rd_en_out  (mem_rd_en_out),
        .inst_valid_out (inst_valid_out),
        .pc_out         (pc_out),
        .inst_out       (inst_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h05;
            32'd2: return 8'h10;
            32'd3: return 8'h00;
            32'd4: return 8'h93;
            32'd5: return 8'h05;
            32'd6: return 8'h20;
            32'd7: return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {ram_byte(pc + 32'd3), ram_byte(pc + 32'd2), ram_byte(pc + 32'd1), ram_byte(pc)};
    endfunction

    // RAM returns the byte for the address seen on the previous cycle
    always @(posedge clk) mem_din_in <= ram_byte(mem_a_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the program-order model and check the invariants.
    task automatic tick;
        logic [31:0] base;
        p_rst   = rst;
        p_jump  = jump_in;
        p_addr  = jump_addr_in;
        p_stall = stall_in;
        p_valid = inst_valid_out;
        @(posedge clk);
        #1;
        if (p_rst)                    exp_pc = 32'h0;
        else if (p_jump)              exp_pc = p_addr;
        else if (p_valid && !p_stall) exp_pc = exp_pc + 32'd4;

        if (p_rst) begin
            check("rst_valid", 32'(inst_valid_out), 32'd0);
        end else if (p_jump) begin
            check("jump_valid_low", 32'(inst_valid_out), 32'd0);
            check("jump_target_addr", mem_a_out, p_addr);
            check("jump_target_rd", 32'(mem_rd_en_out), 32'd1);
        end else if (p_valid && p_stall) begin
            check("stall_hold_valid", 32'(inst_valid_out), 32'd1);
        end
        if (inst_valid_out) begin
            check("model_pc", pc_out, exp_pc);
            check("model_inst", inst_out, word_at(exp_pc));
        end
        if (mem_rd_en_out && !p_rst) begin
            base = inst_valid_out ? exp_pc + 32'd4 : exp_pc;
            check("addr_window", 32'((mem_a_out - base) < 32'd4), 32'd1);
        end
        if (inst_valid_out || p_rst || p_jump || rst) low_run = 0;
        else low_run++;
        total++;
        assert (low_run < 100) else begin
            bad++;
            $error("FAIL liveness: observed %0d idle cycles expected < 100", low_run);
            low_run = 0;
        end
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; jump_in = 1'b0; jump_addr_in = '0; mem_grant_in = 1'b1;
        exp_pc = '0; low_run = 0;

        // Ungated fetch after reset
        tick; tick;
        check("reset_valid", 32'(inst_valid_out), 32'd0);
        check("reset_pc", pc_out, 32'd0);
        check("reset_inst", inst_out, 32'd0);
        check("reset_rd_en", 32'(mem_rd_en_out), 32'd0);
        check("reset_addr", mem_a_out, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("t1_addr", mem_a_out, 32'(k));
            check("t1_rd_en", 32'(mem_rd_en_out), 32'd1);
        end
        tick;
        check("t1_c5_rd_en", 32'(mem_rd_en_out), 32'd0);
        check("t1_c5_valid", 32'(inst_valid_out), 32'd0);
        tick;
        check("t1_c6_valid", 32'(inst_valid_out), 32'd1);
        check("t1_c6_inst", inst_out, 32'h0010_0513);
        check("t1_c6_pc", pc_out, 32'd0);
        check("t1_c6_next_addr", mem_a_out, 32'd4);

        // Grant withheld for two cycles at address 1
        rst = 1'b1; tick; rst = 1'b0;
        tick; tick;
        check("t2_c2_addr", mem_a_out, 32'd1);
        mem_grant_in = 1'b0;
        tick; check("t2_c3_held", mem_a_out, 32'd1);
        tick; check("t2_c4_held", mem_a_out, 32'd1);
        mem_grant_in = 1'b1;
        tick; check("t2_c5_addr", mem_a_out, 32'd2);
        tick; check("t2_c6_addr", mem_a_out, 32'd3);
        tick; check("t2_c7_valid", 32'(inst_valid_out), 32'd0);
        tick;
        check("t2_c8_valid", 32'(inst_valid_out), 32'd1);
        check("t2_c8_inst", inst_out, 32'h0010_0513);

        // Long stall: second word parks in the buffer, no reads while waiting
        rst = 1'b1; tick; rst = 1'b0;
        repeat (6) tick;
        check("t3_c6_valid", 32'(inst_valid_out), 32'd1);
        stall_in = 1'b1;
        for (int c = 7; c <= 18; c++) begin
            tick;
            check("t3_hold_pc", pc_out, 32'd0);
            if (c >= 11) check("t3_wait_no_read", 32'(mem_rd_en_out), 32'd0);
        end
        stall_in = 1'b0;
        tick;
        check("t3_rel_valid", 32'(inst_valid_out), 32'd1);
        check("t3_rel_pc", pc_out, 32'd4);
        check("t3_rel_inst", inst_out, 32'h0020_0593);
        check("t3_rel_addr", mem_a_out, 32'd8);
        check("t3_rel_rd_en", 32'(mem_rd_en_out), 32'd1);

        // Redirect mid-fetch (ic=2)
        rst = 1'b1; tick; rst = 1'b0;
        tick; tick; tick;
        check("t4_c3_addr", mem_a_out, 32'd2);
        jump_in = 1'b1; jump_addr_in = 32'h100;
        tick;
        jump_in = 1'b0;
        check("t4_c4_addr", mem_a_out, 32'h100);
        repeat (4) tick;
        check("t4_c8_valid", 32'(inst_valid_out), 32'd0);
        tick;
        check("t4_c9_valid", 32'(inst_valid_out), 32'd1);
        check("t4_c9_pc", pc_out, 32'h100);
        check("t4_c9_inst", inst_out, word_at(32'h100));

        // Jump with stall while valid, target at top of the address space
        stall_in = 1'b1; jump_in = 1'b1; jump_addr_in = 32'hFFFF_FFFC;
        tick;
        stall_in = 1'b0; jump_in = 1'b0;
        check("t5_jump_valid", 32'(inst_valid_out), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick;
            check("t5_top_addr", mem_a_out, 32'hFFFF_FFFC + 32'(k));
        end
        tick; tick;
        check("t5_valid", 32'(inst_valid_out), 32'd1);
        check("t5_pc", pc_out, 32'hFFFF_FFFC);
        check("t5_inst", inst_out, word_at(32'hFFFF_FFFC));
        check("t5_wrap_addr", mem_a_out, 32'd0);
        tick;
        check("t5_c16_addr", mem_a_out, 32'd1);
        rst = 1'b1;
        tick;
        check("t6_rst_valid", 32'(inst_valid_out), 32'd0);
        check("t6_rst_pc", pc_out, 32'd0);
        check("t6_rst_inst", inst_out, 32'd0);
        check("t6_rst_rd_en", 32'(mem_rd_en_out), 32'd0);
        check("t6_rst_addr", mem_a_out, 32'd0);
        rst = 1'b0;
        tick;
        check("t6_restart_addr", mem_a_out, 32'd0);
        check("t6_restart_rd_en", 32'(mem_rd_en_out), 32'd1);

        // Randomized traffic against the program-order model
        for (int n = 0; n < 3000; n++) begin
            stall_in     = ($urandom_range(0, 99) < 30);
            mem_grant_in = ($urandom_range(0, 99) < 75);
            jump_in      = ($urandom_range(0, 99) < 3);
            jump_addr_in = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            rst          = ($urandom_range(0, 299) == 0);
            tick;
        end
        rst = 1'b0; jump_in = 1'b0; stall_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline, the producer side of the IF→ID instruction interface. Fetches each 32-bit instruction as four little-endian bytes over the shared byte-wide RAM port and presents `pc_out`/`inst_out` with a valid flag to the decode stage. Honours decode/control stalls, loses port cycles to the MEM stage via a grant, and flushes on taken branches or jumps from EX. A one-instruction internal buffer lets the next fetch proceed while the output is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall_in`  in  1  decode/control stall; output is held while high
- `jump_in`  in  1  redirect request from EX (taken branch, JAL, JALR)
- `jump_addr_in`  in  32  redirect target
- `mem_grant_in`  in  1  RAM port granted to fetch this cycle
- `mem_din_in`  in  8  RAM read byte; valid the cycle after its address
- `mem_a_out`  out  32  RAM byte address
- `mem_rd_en_out`  out  1  fetch read request
- `inst_valid_out`  out  1  `pc_out`/`inst_out` hold a valid instruction
- `pc_out`  out  32  PC of presented instruction
- `inst_out`  out  32  presented instruction word

## Operation
- State: `fetch_pc`, issue count `ic` (0..4), receive count `rc` (0..4), `pend` (a byte is due this cycle), byte buffer `buf[23:0]`, engine state FETCH/WAIT, output register (`inst_valid_out`, `pc_out`, `inst_out`).
- Reset: `fetch_pc`=RESET_PC; `ic`=`rc`=0; `pend`=0; state FETCH; `inst_valid_out`=0; `pc_out`=0; `inst_out`=0; `mem_rd_en_out`=0; `mem_a_out`=0.
- Outputs `mem_rd_en_out` = (state FETCH && `ic`<4); `mem_a_out` = `fetch_pc`+`ic` (mod 2^32). Both depend on registers only.
- Issue: an edge with `mem_rd_en_out` && `mem_grant_in` increments `ic` and sets `pend`=1; otherwise `pend`=0. Without a grant, the address is held and nothing advances.
- Receive: an edge with `pend`=1 stores `mem_din_in` at byte `rc` (bytes 0..2 into `buf`) and increments `rc`.
- Completion: the edge that receives byte 3 forms {`mem_din_in`, `buf`}.
  - If the output register is free, the word moves to the output with `pc_out`=`fetch_pc` and `inst_valid_out`=1. Then `fetch_pc`+=4 (wraps), `ic`=`rc`=0, and state stays FETCH.
  - Otherwise the byte is stored and state becomes WAIT.
- Output free: `inst_valid_out`=0, or `stall_in`=0 (the presented instruction is consumed at that edge).
- Consumption: an edge with `inst_valid_out`=1 and `stall_in`=0 consumes the presented instruction. If no new word loads at that edge, `inst_valid_out` falls to 0.
- WAIT: when the output is free, the buffered word loads, `fetch_pc`+=4, `ic`=`rc`=0, and state returns to FETCH. The engine issues no reads in WAIT.
- Redirect (`jump_in`=1 at an edge) has priority over stall, completion and issue:
  - `fetch_pc`=`jump_addr_in`; `ic`=`rc`=0; `pend`=0 (any in-flight byte is dropped); state FETCH; `inst_valid_out`=0.
  - `pc_out`/`inst_out` keep their stale values.
- Stall never blocks fetching until both the buffer and the output are full.

## Timing
- Ungated fetch: addresses at cycles t..t+3, bytes arrive t+1..t+4, `inst_valid_out` high from t+5.
- Each cycle of `mem_grant_in`=0 during issue adds one cycle of latency.
- Steady-state throughput without stall: one instruction per 5 cycles; the next address issues in the first cycle `inst_valid_out` is high.
- After a redirect edge: target address appears next cycle; `inst_valid_out` is low for at least 5 cycles.
- `rst` has priority over `jump_in`; reset mid-fetch discards all progress.

## Test plan
- Reset, RESET_PC=0, RAM[0..3]=13 05 10 00, grant tied high → `mem_a_out` 0,1,2,3 on cycles 1–4; `inst_valid_out`=1 at cycle 6 with `inst_out`=0x00100513 and `pc_out`=0.
- Same stimulus with `mem_grant_in`=0 for 2 cycles while `mem_a_out`=1 → address 1 is held; valid arrives 2 cycles later; word is unchanged.
- `stall_in` high for 12 cycles after the first valid, RAM[4..7]=93 05 20 00 → output held at pc 0; no reads once in WAIT. On release: the next cycle shows `pc_out`=4, `inst_out`=0x00200593, `inst_valid_out` continuously high. Fetch of pc 8 then starts.
- `jump_in`=1, `jump_addr_in`=0x100 while `ic`=2 → next cycle `mem_a_out`=0x100 and `inst_valid_out`=0; the returning byte for address 2 is ignored. Word at 0x100 is delivered with `pc_out`=0x100.
- `jump_in` and `stall_in` both high while valid → `inst_valid_out`=0 next cycle; fetch restarts at the target.
- Jump to 0xFFFFFFFC → addresses FFFFFFFC..FFFFFFFF, `pc_out`=0xFFFFFFFC, next fetch address 0x00000000. Assert `rst` mid-fetch → next cycle all outputs are at reset values and fetch restarts at RESET_PC.
